// File: rtl/spi_controller.sv
// SPI mode-0 initiator: shifts one 16-bit frame {rw, addr[6:0], data[7:0]} MSB first
// and captures the last eight cipo bits as read data.
module spi_controller #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter int unsigned CS_GAP   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic       req_write_i,
    input  logic [6:0] req_addr_i,
    input  logic [7:0] req_data_i,
    input  logic       cipo_i,
    output logic       sclk_o,
    output logic       copi_o,
    output logic       ncs_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] rd_data_o
);

    localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned CntMax = (CS_SETUP > CS_HOLD) ?
                                     ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP) :
                                     ((CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP);
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

    typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [DivW-1:0]   div_q;
    logic [3:0]        bit_q;
    logic [15:0]       shift_q;
    logic [7:0]        rx_q;
    logic [7:0]        rd_data_q;
    logic              sclk_q, copi_q, ncs_q, busy_q, done_q, ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            div_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            rx_q      <= '0;
            rd_data_q <= '0;
            sclk_q    <= 1'b0;
            copi_q    <= 1'b0;
            ncs_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        shift_q <= {req_write_i, req_addr_i, req_data_i};
                        copi_q  <= req_write_i;
                        ncs_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        cnt_q   <= CntW'(CS_SETUP - 1);
                        state_q <= StSetup;
                    end
                end
                StSetup: begin
                    if (cnt_q == '0) begin
                        div_q   <= DivW'(CLK_DIV - 1);
                        bit_q   <= 4'd15;
                        state_q <= StShift;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StShift: begin
                    if (div_q != '0) begin
                        div_q <= div_q - DivW'(1);
                    end else if (!sclk_q) begin
                        sclk_q <= 1'b1;
                        rx_q   <= {rx_q[6:0], cipo_i};
                        div_q  <= DivW'(CLK_DIV - 1);
                    end else begin
                        // Falling edge: either present the next bit or leave for HOLD.
                        sclk_q <= 1'b0;
                        if (bit_q == 4'd0) begin
                            cnt_q   <= CntW'(CS_HOLD - 1);
                            state_q <= StHold;
                        end else begin
                            bit_q   <= bit_q - 4'd1;
                            shift_q <= {shift_q[14:0], 1'b0};
                            copi_q  <= shift_q[14];
                            div_q   <= DivW'(CLK_DIV - 1);
                        end
                    end
                end
                StHold: begin
                    if (cnt_q == '0) begin
                        ncs_q     <= 1'b1;
                        copi_q    <= 1'b0;
                        done_q    <= 1'b1;
                        rd_data_q <= rx_q;
                        cnt_q     <= CntW'(CS_GAP - 1);
                        state_q   <= StGap;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StGap: begin
                    if (cnt_q == '0) begin
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready_o = ready_q;
    assign sclk_o      = sclk_q;
    assign copi_o      = copi_q;
    assign ncs_o       = ncs_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign rd_data_o   = rd_data_q;

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: table of frames plus reset, back-to-back and
// minimum-timing sequences, observed on the pins cycle by cycle.
module tb_spi_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_write = 1'b0;
    logic [6:0] req_addr = '0;
    logic [7:0] req_data = '0;
    logic       cipo = 1'b0;
    logic       sel = 1'b0;

    logic       ready_a, sclk_a, copi_a, ncs_a, busy_a, done_a;
    logic       ready_b, sclk_b, copi_b, ncs_b, busy_b, done_b;
    logic [7:0] rd_a, rd_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    spi_controller u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid & ~sel), .req_ready_o(ready_a),
        .req_write_i(req_write), .req_addr_i(req_addr), .req_data_i(req_data),
        .cipo_i(cipo), .sclk_o(sclk_a), .copi_o(copi_a), .ncs_o(ncs_a), .busy_o(busy_a),
        .done_o(done_a), .rd_data_o(rd_a)
    );

    spi_controller #(.CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(1)) u_dut_fast (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid & sel), .req_ready_o(ready_b),
        .req_write_i(req_write), .req_addr_i(req_addr), .req_data_i(req_data),
        .cipo_i(cipo), .sclk_o(sclk_b), .copi_o(copi_b), .ncs_o(ncs_b), .busy_o(busy_b),
        .done_o(done_b), .rd_data_o(rd_b)
    );

    wire       ready_w = sel ? ready_b : ready_a;
    wire       sclk_w  = sel ? sclk_b  : sclk_a;
    wire       copi_w  = sel ? copi_b  : copi_a;
    wire       ncs_w   = sel ? ncs_b   : ncs_a;
    wire       busy_w  = sel ? busy_b  : busy_a;
    wire       done_w  = sel ? done_b  : done_a;
    wire [7:0] rd_w    = sel ? rd_b    : rd_a;

    typedef struct {
        logic        w;
        logic [6:0]  addr;
        logic [7:0]  data;
        logic [7:0]  cipo_byte;
        logic [15:0] exp_bits;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_idle();
        int cyc = 0;
        while (!ready_w && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("return_to_idle", int'(ready_w & ~busy_w), 1);
    endtask

    // Issue one request and follow it to done, checking the pin-level frame.
    task automatic run_frame(input string nm, input logic w, input logic [6:0] a,
                             input logic [7:0] d, input logic [7:0] cb,
                             input logic [15:0] exp_bits, input logic [7:0] exp_rd,
                             input int exp_low, input int div);
        int low = 0, rises = 0, stable = 0, cyc = 0;
        bit got_done = 0, setup_ok = 1;
        logic [15:0] bits = '0;
        logic pn, ps, pc;
        check({nm, "_ready_before"}, int'(ready_w), 1);
        req_write = w; req_addr = a; req_data = d; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = ~w; req_addr = ~a; req_data = ~d;
        pn = 1'b1; ps = 1'b0; pc = 1'b0;
        while (!got_done && cyc < 400) begin
            if (sclk_w && !ps) begin
                if (stable < div) setup_ok = 0;
                bits = {bits[14:0], copi_w};
                rises++;
            end
            if (copi_w != pc) stable = 1;
            else stable++;
            if (!ncs_w) low++;
            if (!ncs_w && !sclk_w)
                cipo = (rises >= 8 && rises < 16) ? cb[15 - rises] : rises[0];
            if (done_w) begin
                got_done = 1;
                check({nm, "_done_at_ncs_rise"}, int'({pn, ncs_w}), 1);
                check({nm, "_busy_at_done"}, int'(busy_w), 1);
                check({nm, "_rd_data"}, int'(rd_w), int'(exp_rd));
            end
            pn = ncs_w; ps = sclk_w; pc = copi_w;
            if (!got_done) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        check({nm, "_done_seen"}, int'(got_done), 1);
        check({nm, "_bits"}, int'(bits), int'(exp_bits));
        check({nm, "_ncs_low_cycles"}, low, exp_low);
        check({nm, "_sclk_rises"}, rises, 16);
        check({nm, "_copi_setup"}, int'(setup_ok), 1);
        @(posedge clk); #1;
        check({nm, "_done_one_cycle"}, int'(done_w), 0);
        check({nm, "_rd_held"}, int'(rd_w), int'(exp_rd));
        wait_idle();
    endtask

    initial begin
        vecs[0] = '{1'b1, 7'h00, 8'hFF, 8'h00, 16'h80FF, 8'h00};
        vecs[1] = '{1'b1, 7'h01, 8'hA5, 8'h5A, 16'h81A5, 8'h5A};
        vecs[2] = '{1'b0, 7'h04, 8'hE1, 8'h3C, 16'h04E1, 8'h3C};
        vecs[3] = '{1'b1, 7'h7F, 8'h5A, 8'hC3, 16'hFF5A, 8'hC3};

        repeat (3) @(posedge clk);
        #1;
        check("reset_ncs", int'(ncs_w), 1);
        check("reset_sclk", int'(sclk_w), 0);
        check("reset_copi", int'(copi_w), 0);
        check("reset_busy", int'(busy_w), 0);
        check("reset_done", int'(done_w), 0);
        check("reset_ready", int'(ready_w), 1);
        check("reset_rd_data", int'(rd_w), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++)
            run_frame($sformatf("vec%0d", i), vecs[i].w, vecs[i].addr, vecs[i].data,
                      vecs[i].cipo_byte, vecs[i].exp_bits, vecs[i].exp_rd, 132, 4);

        // Reset during bit 7 of a frame.
        begin
            int rises = 0, cyc = 0;
            logic ps = 1'b0;
            req_write = 1'b1; req_addr = 7'h06; req_data = 8'h77; req_valid = 1'b1;
            @(posedge clk); #1;
            req_valid = 1'b0;
            while (!(rises == 8 && !sclk_w) && cyc < 400) begin
                if (sclk_w && !ps) rises++;
                ps = sclk_w;
                if (!(rises == 8 && !sclk_w)) begin
                    @(posedge clk); #1;
                    cyc++;
                end
            end
            check("rst_reached_bit7", rises, 8);
            @(posedge clk); #2;
            rst_n = 1'b0;
            #1;
            check("rst_mid_ncs", int'(ncs_w), 1);
            check("rst_mid_sclk", int'(sclk_w), 0);
            check("rst_mid_copi", int'(copi_w), 0);
            check("rst_mid_busy", int'(busy_w), 0);
            check("rst_mid_rd_data", int'(rd_w), 0);
            for (int i = 0; i < 3; i++) begin
                @(posedge clk); #1;
                check("rst_mid_no_done", int'(done_w), 0);
            end
            rst_n = 1'b1;
            @(posedge clk); #1;
            check("rst_after_ready", int'(ready_w), 1);
            run_frame("post_rst", 1'b1, 7'h02, 8'h0F, 8'h96, 16'h820F, 8'h96, 132, 4);
        end

        // Back-to-back requests with req_valid held high.
        begin
            int falls = 0, gap = 0, rdy = 0, cyc = 0;
            logic pn;
            req_write = 1'b1; req_addr = 7'h03; req_data = 8'h11; req_valid = 1'b1;
            @(posedge clk); #1;
            pn = ncs_w;
            check("b2b_first_accept", int'(ncs_w), 0);
            while (falls < 1 && cyc < 600) begin
                @(posedge clk); #1;
                cyc++;
                if (ready_w) rdy++;
                if (ncs_w) gap++;
                if (!ncs_w && pn) falls++;
                pn = ncs_w;
            end
            req_valid = 1'b0;
            check("b2b_second_accept", falls, 1);
            check("b2b_gap_ge_5", int'(gap >= 5), 1);
            check("b2b_ready_cycles", rdy, 1);
            cyc = 0;
            while (!done_w && cyc < 400) begin
                @(posedge clk); #1;
                cyc++;
            end
            check("b2b_second_done", int'(done_w), 1);
            wait_idle();
        end

        sel = 1'b1;
        @(posedge clk); #1;
        run_frame("fast", 1'b1, 7'h05, 8'h96, 8'h69, 16'h8596, 8'h69, 66, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
